// File: rtl/audio_mixer_pkg.sv
// Shared types and helpers for the time-multiplexed audio mixer.
// Optional PEAK register is enabled with AUDIO_MIXER_PEAK_EN.
package audio_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [5:0] REG_CTRL   = 6'd0;
    localparam logic [5:0] REG_STATUS = 6'd1;
    localparam logic [5:0] REG_PEAK   = 6'd2;

    localparam int STAT_OVERRUN = 0;
    localparam int STAT_CLIP    = 1;

    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            return hi;
        if (value < lo)
            return lo;
        return value;
    endfunction

endpackage

// File: rtl/audio_mixer_regs.sv
// Bus register file: per-channel volume, CTRL, sticky W1C STATUS and
// (with AUDIO_MIXER_PEAK_EN) a clear-on-read PEAK magnitude register.
module audio_mixer_regs
    import audio_mixer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int VOL_W = 4,
    parameter int OUT_W = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  valid,
    output logic                  ready,
    input  logic [3:0]            wstrb,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [N_CH*VOL_W-1:0] vol,
    output logic                  enable,
    input  logic                  set_overrun,
    input  logic                  set_clip,
    input  logic                  peak_upd,
    input  logic [OUT_W-2:0]      peak_mag
);

    logic [VOL_W-1:0] vol_q [N_CH];
    logic [1:0]       status_q;
    logic [1:0]       clr;
    logic [1:0]       set;
    logic [5:0]       word;
    logic             wr;
    logic [31:0]      rd_val;
    logic             unused_bits;

    assign word = addr[7:2];
    assign wr   = valid && wstrb[0];
    assign unused_bits = ^{wstrb, addr, wdata};

    always_comb begin
        for (int i = 0; i < N_CH; i++)
            vol[i*VOL_W +: VOL_W] = vol_q[i];
    end

    always_comb begin
        clr = '0;
        if (wr && addr[8] && word == REG_STATUS)
            clr = wdata[1:0];
        set = '0;
        set[STAT_OVERRUN] = set_overrun;
        set[STAT_CLIP]    = set_clip;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_CH; i++)
                vol_q[i] <= '0;
            enable   <= 1'b1;
            status_q <= '0;
        end else begin
            if (wr && !addr[8]) begin
                for (int i = 0; i < N_CH; i++)
                    if (word == 6'(i))
                        vol_q[i] <= wdata[VOL_W-1:0];
            end
            if (wr && addr[8] && word == REG_CTRL)
                enable <= wdata[0];
            // set wins over a same-cycle clear
            status_q <= (status_q & ~clr) | set;
        end
    end

`ifdef AUDIO_MIXER_PEAK_EN
    logic [OUT_W-2:0] peak_q;
    logic             peak_rd;

    assign peak_rd = valid && !wstrb[0] && addr[8] && word == REG_PEAK;

    always_ff @(posedge clk) begin
        if (!resetn)
            peak_q <= '0;
        else if (peak_rd)
            peak_q <= peak_upd ? peak_mag : '0;
        else if (peak_upd && peak_mag > peak_q)
            peak_q <= peak_mag;
    end
`else
    logic unused_peak;
    assign unused_peak = ^{peak_upd, peak_mag};
`endif

    always_comb begin
        rd_val = '0;
        if (!addr[8]) begin
            for (int i = 0; i < N_CH; i++)
                if (word == 6'(i))
                    rd_val[VOL_W-1:0] = vol_q[i];
        end else begin
            case (word)
                REG_CTRL:   rd_val[0]   = enable;
                REG_STATUS: rd_val[1:0] = status_q;
`ifdef AUDIO_MIXER_PEAK_EN
                REG_PEAK:   rd_val[OUT_W-2:0] = peak_q;
`endif
                default:    rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= valid;
            rdata <= rd_val;
        end
    end

endmodule

// File: rtl/audio_mixer_seq.sv
// Tick-driven mixer: one multiply-accumulate per clock, saturated output.
// Build with AUDIO_MIXER_PEAK_EN for the PEAK magnitude register.
module audio_mixer_seq
    import audio_mixer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int IN_W  = 8,
    parameter int VOL_W = 4,
    parameter int OUT_W = 12,
    parameter int SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 valid,
    output logic                 ready,
    input  logic [3:0]           wstrb,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic                 tick,
    input  logic [N_CH*IN_W-1:0] ch_in,
    output logic [OUT_W-1:0]     out,
    output logic                 out_valid,
    output logic                 busy
);

    localparam int ACC_W  = IN_W + VOL_W + 1 + $clog2(N_CH);
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int MID_IN = 2 ** (IN_W - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);
    localparam logic [OUT_W-1:0] MID_OUT = {1'b1, {(OUT_W-1){1'b0}}};

    state_t state, state_nx;
    logic   start;
    logic   enable;

    logic [N_CH*VOL_W-1:0]   vol;
    logic [IN_W-1:0]         shadow [N_CH];
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] samp_s;
    logic signed [ACC_W-1:0] vol_s;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] shifted;
    logic signed [63:0]      sat_val;
    logic [OUT_W-1:0]        s_out;
    logic                    clip_now;
    logic [OUT_W-2:0]        peak_mag;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        unique case (state)
            IDLE: if (tick && enable) begin
                state_nx = ACC;
                start    = 1'b1;
            end
            ACC:  if (idx == LAST) state_nx = OUT;
            OUT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Offset-binary sample to signed, times live volume.
    assign samp_s = $signed(ACC_W'(shadow[idx])) - $signed(ACC_W'(MID_IN));
    assign vol_s  = $signed(ACC_W'(vol[idx*VOL_W +: VOL_W]));
    assign prod   = samp_s * vol_s;

    assign shifted  = acc >>> SHIFT;
    assign sat_val  = sat_signed(64'(shifted), OUT_W);
    assign s_out    = sat_val[OUT_W-1:0];
    assign clip_now = (sat_val != 64'(shifted));

    always_ff @(posedge clk) begin
        if (start) begin
            for (int k = 0; k < N_CH; k++)
                shadow[k] <= ch_in[k*IN_W +: IN_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc       <= '0;
            idx       <= '0;
            out       <= MID_OUT;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (start) begin
                acc <= '0;
                idx <= '0;
            end else if (state == ACC) begin
                acc <= acc + prod;
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
            if (state == OUT) begin
                out       <= {~s_out[OUT_W-1], s_out[OUT_W-2:0]};
                out_valid <= 1'b1;
            end
        end
    end

`ifdef AUDIO_MIXER_PEAK_EN
    logic [OUT_W-1:0] neg_out;
    assign neg_out = -s_out;
    // Most negative code has no positive twin; report full scale.
    assign peak_mag = !s_out[OUT_W-1] ? s_out[OUT_W-2:0] :
                      neg_out[OUT_W-1] ? '1 : neg_out[OUT_W-2:0];
`else
    assign peak_mag = '0;
`endif

    audio_mixer_regs #(
        .N_CH  (N_CH),
        .VOL_W (VOL_W),
        .OUT_W (OUT_W)
    ) u_regs (
        .clk         (clk),
        .resetn      (resetn),
        .valid       (valid),
        .ready       (ready),
        .wstrb       (wstrb),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .vol         (vol),
        .enable      (enable),
        .set_overrun (tick && busy),
        .set_clip    ((state == OUT) && clip_now),
        .peak_upd    (state == OUT),
        .peak_mag    (peak_mag)
    );

endmodule

// File: tb/tb_audio_mixer_seq.sv
// Scoreboard bench: default mixer plus a SHIFT=0 instance for clipping.
module tb_audio_mixer_seq;

    localparam int N_CH  = 4;
    localparam int IN_W  = 8;
    localparam int VOL_W = 4;
    localparam int OUT_W = 12;

    localparam logic [31:0] A_CTRL   = 32'h100;
    localparam logic [31:0] A_STATUS = 32'h104;
    localparam logic [31:0] A_PEAK   = 32'h108;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic valid = 1'b0;
    logic tick = 1'b0;
    logic tick_s = 1'b0;
    logic [3:0]  wstrb = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [N_CH*IN_W-1:0] ch_in = '0;

    logic [31:0]      rdata, rdata_s;
    logic             ready, ready_s;
    logic [OUT_W-1:0] out, out_s;
    logic             out_valid, out_valid_s;
    logic             busy, busy_s;

    int errors = 0;
    int checks = 0;
    logic [OUT_W-1:0] q_exp [$];
    logic [OUT_W-1:0] q_exp_s [$];

    always #5 clk = ~clk;

    audio_mixer_seq #(
        .N_CH(N_CH), .IN_W(IN_W), .VOL_W(VOL_W), .OUT_W(OUT_W), .SHIFT(2)
    ) u_dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .rdata(rdata),
        .tick(tick), .ch_in(ch_in), .out(out), .out_valid(out_valid),
        .busy(busy)
    );

    audio_mixer_seq #(
        .N_CH(N_CH), .IN_W(IN_W), .VOL_W(VOL_W), .OUT_W(OUT_W), .SHIFT(0)
    ) u_sat (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready_s),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .rdata(rdata_s),
        .tick(tick_s), .ch_in(ch_in), .out(out_s), .out_valid(out_valid_s),
        .busy(busy_s)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid) begin
            if (q_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_valid: unexpected pulse, out=%0h", out);
            end else begin
                chk("out", 32'(out), 32'(q_exp.pop_front()));
            end
        end
        if (resetn && out_valid_s) begin
            if (q_exp_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_sat: unexpected pulse, out=%0h", out_s);
            end else begin
                chk("out_sat", 32'(out_s), 32'(q_exp_s.pop_front()));
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        valid = 1'b1; wstrb = 4'h1; addr = a; wdata = d;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d,
                      output logic [31:0] ds);
        @(negedge clk);
        valid = 1'b1; wstrb = 4'h0; addr = a;
        @(negedge clk);
        chk("ready", 32'(ready), 32'd1);
        d = rdata;
        ds = rdata_s;
        valid = 1'b0;
    endtask

    task automatic pulse(input bit sat);
        @(negedge clk);
        if (sat) tick_s = 1'b1; else tick = 1'b1;
        @(negedge clk);
        tick = 1'b0; tick_s = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_vols(input logic [3:0] v0, input logic [3:0] vr);
        wr(32'h0, 32'(v0));
        for (int k = 1; k < N_CH; k++)
            wr(32'(k * 4), 32'(vr));
    endtask

    logic [31:0] d, ds;
    int lat, nbusy;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst out", 32'(out), 32'h800);
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        rd(A_CTRL, d, ds);
        chk("rst ctrl", d, 32'd1);
        rd(A_STATUS, d, ds);
        chk("rst status", d, 32'd0);

        // silence frame with zero volume, latency and busy span
        ch_in = {N_CH{8'hFF}};
        q_exp.push_back(12'h800);
        @(negedge clk);
        tick = 1'b1;
        lat = 0;
        nbusy = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            tick = 1'b0;
            if (busy) nbusy++;
            if (out_valid && lat == 0) lat = c;
        end
        chk("latency", 32'(lat), 32'(N_CH + 2));
        chk("busy cycles", 32'(nbusy), 32'(N_CH + 1));

        // full-scale mixes
        set_vols(4'd15, 4'd15);
        wr(32'h14, 32'd7);
        rd(32'h14, d, ds);
        chk("vol oob", d, 32'd0);
        rd(32'h0C, d, ds);
        chk("vol3", d, 32'd15);
        q_exp.push_back(12'hF71);
        pulse(1'b0);
        idle(8);
        ch_in = {N_CH{8'h00}};
        q_exp.push_back(12'h080);
        pulse(1'b0);
        idle(8);
        rd(A_STATUS, d, ds);
        chk("status noclip", d, 32'd0);

        // clipping on the SHIFT=0 instance
        ch_in = {N_CH{8'hFF}};
        q_exp_s.push_back(12'hFFF);
        pulse(1'b1);
        idle(8);
        ch_in = {N_CH{8'h00}};
        q_exp_s.push_back(12'h000);
        pulse(1'b1);
        idle(8);
        rd(A_STATUS, d, ds);
        chk("status clip", ds, 32'h2);
        chk("status dut", d, 32'h0);
        wr(A_STATUS, 32'h2);
        rd(A_STATUS, d, ds);
        chk("status w1c", ds, 32'h0);

        // snapshot: ch0 changes after the tick
        set_vols(4'd8, 4'd0);
        ch_in = {N_CH{8'h80}};
        ch_in[7:0] = 8'hC0;
        q_exp.push_back(12'h880);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        ch_in[7:0] = 8'h00;
        idle(8);

        // overrun: second tick two cycles later is dropped
        wr(A_STATUS, 32'h3);
        ch_in = {N_CH{8'h80}};
        q_exp.push_back(12'h800);
        pulse(1'b0);
        pulse(1'b0);
        idle(8);
        rd(A_STATUS, d, ds);
        chk("overrun", d, 32'h1);

        // disabled: tick ignored
        wr(A_STATUS, 32'h3);
        wr(A_CTRL, 32'h0);
        rd(A_CTRL, d, ds);
        chk("ctrl off", d, 32'h0);
        pulse(1'b0);
        idle(8);
        rd(A_STATUS, d, ds);
        chk("status disabled", d, 32'h0);
        wr(A_CTRL, 32'h1);

        // peak register
        set_vols(4'd15, 4'd15);
        rd(A_PEAK, d, ds);
        ch_in = {N_CH{8'hFF}};
        q_exp.push_back(12'hF71);
        pulse(1'b0);
        idle(8);
        rd(A_PEAK, d, ds);
`ifdef AUDIO_MIXER_PEAK_EN
        chk("peak", d, 32'h771);
`else
        chk("peak absent", d, 32'h0);
`endif
        rd(A_PEAK, d, ds);
        chk("peak cleared", d, 32'h0);

        // reset mid-frame
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("busy mid", 32'(busy), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rst mid out", 32'(out), 32'h800);
        chk("rst mid busy", 32'(busy), 32'd0);
        chk("rst mid out_valid", 32'(out_valid), 32'd0);
        idle(8);
        rd(32'h0, d, ds);
        chk("rst mid vol0", d, 32'd0);
        rd(A_CTRL, d, ds);
        chk("rst mid ctrl", d, 32'd1);

        idle(4);
        chk("queue drained", 32'(q_exp.size()), 32'd0);
        chk("queue_s drained", 32'(q_exp_s.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
